// File: rtl/stream_mux_rr.sv
// Registered N-to-1 stream mux with round-robin or fixed-priority arbitration
// and optional per-packet grant locking.
module stream_mux_rr #(
    parameter int WIDTH       = 8,
    parameter int NUM         = 4,
    parameter int RR_MODE     = 1,
    parameter int PACKET_LOCK = 1,
    parameter int CHW         = 2
) (
    input  logic                 clk,
    input  logic                 n_rst,
    input  logic [NUM*WIDTH-1:0] in_data_bus,
    input  logic [NUM-1:0]       in_valid_bus,
    input  logic [NUM-1:0]       in_last_bus,
    output logic [NUM-1:0]       in_ready_bus,
    output logic [WIDTH-1:0]     out_data,
    output logic                 out_last,
    output logic [CHW-1:0]       out_chan,
    output logic                 out_valid,
    input  logic                 out_ready
);

    localparam logic [0:0] S_IDLE   = 1'b0;
    localparam logic [0:0] S_LOCKED = 1'b1;

    logic [0:0]       state_q, state_d;
    logic [CHW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [CHW-1:0]   lock_chan_q, lock_chan_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             last_q, last_d;
    logic             valid_q, valid_d;
    logic [CHW-1:0]   chan_q, chan_d;

    logic             load;
    logic             found;
    logic [NUM-1:0]   gnt_oh;
    logic [NUM-1:0]   xfer_oh;
    logic             xfer;
    logic             xfer_last;
    logic [WIDTH-1:0] xfer_data;
    logic [CHW-1:0]   gnt_idx;
    logic [CHW-1:0]   ptr_next;

    assign load = !valid_q || out_ready;

    // Grant is purely combinational; a stalled output simply withholds ready.
    always_comb begin
        gnt_oh = '0;
        found  = 1'b0;
        if (state_q == S_LOCKED) begin
            for (int i = 0; i < NUM; i++) begin
                gnt_oh[i] = (CHW'(i) == lock_chan_q);
            end
        end else if (RR_MODE != 0) begin
            for (int k = 0; k < NUM; k++) begin
                for (int i = 0; i < NUM; i++) begin
                    if (!found && in_valid_bus[i] && (i == (int'(rr_ptr_q) + k) % NUM)) begin
                        gnt_oh[i] = 1'b1;
                        found     = 1'b1;
                    end
                end
            end
        end else begin
            for (int i = 0; i < NUM; i++) begin
                if (!found && in_valid_bus[i]) begin
                    gnt_oh[i] = 1'b1;
                    found     = 1'b1;
                end
            end
        end
    end

    assign in_ready_bus = gnt_oh & {NUM{load & n_rst}};
    assign xfer_oh      = in_valid_bus & in_ready_bus;
    assign xfer         = |xfer_oh;

    always_comb begin
        xfer_data = '0;
        xfer_last = 1'b0;
        gnt_idx   = '0;
        for (int i = 0; i < NUM; i++) begin
            xfer_data = xfer_data | (in_data_bus[i*WIDTH +: WIDTH] & {WIDTH{xfer_oh[i]}});
            xfer_last = xfer_last | (in_last_bus[i] & xfer_oh[i]);
            if (gnt_oh[i]) gnt_idx = CHW'(i);
        end
    end

    assign ptr_next = (int'(gnt_idx) == NUM - 1) ? '0 : gnt_idx + CHW'(1);

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        lock_chan_d = lock_chan_q;
        data_d      = data_q;
        last_d      = last_q;
        valid_d     = valid_q;
        chan_d      = chan_q;
        if (load) begin
            valid_d = xfer;
            if (xfer) begin
                data_d = xfer_data;
                last_d = xfer_last;
                chan_d = gnt_idx;
            end
        end
        if (xfer) begin
            if (state_q == S_IDLE) begin
                if ((PACKET_LOCK != 0) && !xfer_last) begin
                    state_d     = S_LOCKED;
                    lock_chan_d = gnt_idx;
                end
            end else if (xfer_last) begin
                state_d = S_IDLE;
            end
            // Pointer advances only when a grant ends, so a locked packet is one turn.
            if ((RR_MODE != 0) && ((PACKET_LOCK == 0) || xfer_last)) begin
                rr_ptr_d = ptr_next;
            end
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q     <= S_IDLE;
            rr_ptr_q    <= '0;
            lock_chan_q <= '0;
            data_q      <= '0;
            last_q      <= 1'b0;
            valid_q     <= 1'b0;
            chan_q      <= '0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            lock_chan_q <= lock_chan_d;
            data_q      <= data_d;
            last_q      <= last_d;
            valid_q     <= valid_d;
            chan_q      <= chan_d;
        end
    end

    assign out_data  = data_q;
    assign out_last  = last_q;
    assign out_chan  = chan_q;
    assign out_valid = valid_q;

endmodule

// File: tb/tb_stream_mux_rr.sv
// Scoreboard bench: unit 0 is round-robin with packet lock, unit 1 is fixed
// priority without lock; a reference model predicts ready and output beats.
module tb_stream_mux_rr;

    localparam int WIDTH = 8;
    localparam int NUM   = 4;
    localparam int CHW   = 2;

    logic                 clk = 1'b0;
    logic                 n_rst;
    logic [NUM*WIDTH-1:0] dat  [2];
    logic [NUM-1:0]       vld  [2];
    logic [NUM-1:0]       lst  [2];
    logic [NUM-1:0]       rdy  [2];
    logic [WIDTH-1:0]     od   [2];
    logic                 ol   [2];
    logic [CHW-1:0]       oc   [2];
    logic                 ov   [2];
    logic                 ordy [2];

    int total = 0;
    int bad   = 0;

    int               len     [2][NUM];
    int               seq     [2][NUM];
    logic [NUM-1:0]   acc     [2];
    int               m_state [2];
    int               m_ptr   [2];
    int               m_lock  [2];
    bit               m_ov    [2];
    logic [10:0]      q0 [$];
    logic [10:0]      q1 [$];

    always #5 clk = ~clk;

    stream_mux_rr #(.WIDTH(WIDTH), .NUM(NUM), .RR_MODE(1), .PACKET_LOCK(1), .CHW(CHW)) u_a (
        .clk(clk), .n_rst(n_rst), .in_data_bus(dat[0]), .in_valid_bus(vld[0]),
        .in_last_bus(lst[0]), .in_ready_bus(rdy[0]), .out_data(od[0]), .out_last(ol[0]),
        .out_chan(oc[0]), .out_valid(ov[0]), .out_ready(ordy[0])
    );

    stream_mux_rr #(.WIDTH(WIDTH), .NUM(NUM), .RR_MODE(0), .PACKET_LOCK(0), .CHW(CHW)) u_b (
        .clk(clk), .n_rst(n_rst), .in_data_bus(dat[1]), .in_valid_bus(vld[1]),
        .in_last_bus(lst[1]), .in_ready_bus(rdy[1]), .out_data(od[1]), .out_last(ol[1]),
        .out_chan(oc[1]), .out_valid(ov[1]), .out_ready(ordy[1])
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_unit(input int u);
        logic [NUM-1:0] er;
        logic [10:0]    e;
        int             g;
        bit             ld;
        if (!n_rst) begin
            chk($sformatf("rst_ready_%0d", u), 32'(rdy[u]), 0);
            chk($sformatf("rst_valid_%0d", u), 32'(ov[u]), 0);
            chk($sformatf("rst_data_%0d", u), 32'(od[u]), 0);
            chk($sformatf("rst_chan_%0d", u), 32'(oc[u]), 0);
            m_state[u] = 0; m_ptr[u] = 0; m_lock[u] = 0; m_ov[u] = 0; acc[u] = '0;
            if (u == 0) q0.delete(); else q1.delete();
            return;
        end
        ld = !m_ov[u] || ordy[u];
        er = '0;
        g  = -1;
        if (m_state[u] == 1) g = m_lock[u];
        else begin
            for (int k = 0; k < NUM; k++) begin
                int c;
                c = (u == 0) ? (m_ptr[u] + k) % NUM : k;
                if (g < 0 && vld[u][c]) g = c;
            end
        end
        if (g >= 0 && ld) er[g] = 1'b1;
        chk($sformatf("ready_%0d", u), 32'(rdy[u]), 32'(er));
        chk($sformatf("out_valid_%0d", u), 32'(ov[u]), 32'(m_ov[u]));
        if (m_ov[u] && ordy[u]) begin
            int sz;
            sz = (u == 0) ? q0.size() : q1.size();
            if (sz == 0) chk($sformatf("beat_avail_%0d", u), 32'(sz), 1);
            else begin
                e = (u == 0) ? q0.pop_front() : q1.pop_front();
                chk($sformatf("beat_%0d", u), 32'({oc[u], ol[u], od[u]}), 32'(e));
            end
        end
        acc[u] = vld[u] & er;
        if (|acc[u]) begin
            e = {CHW'(g), lst[u][g], dat[u][g*WIDTH +: WIDTH]};
            if (u == 0) q0.push_back(e); else q1.push_back(e);
            if (u == 0) begin
                if (m_state[0] == 0 && !lst[0][g]) begin
                    m_state[0] = 1;
                    m_lock[0]  = g;
                end else if (m_state[0] == 1 && lst[0][g]) m_state[0] = 0;
                if (lst[0][g]) m_ptr[0] = (g + 1) % NUM;
            end
        end
        if (ld) m_ov[u] = |acc[u];
    endtask

    always @(negedge clk) begin
        for (int u = 0; u < 2; u++) check_unit(u);
    end

    task automatic apply();
        for (int u = 0; u < 2; u++)
            for (int i = 0; i < NUM; i++) begin
                vld[u][i] = len[u][i] > 0;
                lst[u][i] = len[u][i] == 1;
                dat[u][i*WIDTH +: WIDTH] = {4'(i), 4'(seq[u][i])};
            end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        for (int u = 0; u < 2; u++)
            for (int i = 0; i < NUM; i++)
                if (acc[u][i]) begin
                    len[u][i]--;
                    seq[u][i]++;
                end
        apply();
    endtask

    function automatic bit busy();
        bit b;
        b = (q0.size() != 0) || (q1.size() != 0) || m_ov[0] || m_ov[1];
        for (int u = 0; u < 2; u++)
            for (int i = 0; i < NUM; i++)
                if (len[u][i] > 0) b = 1'b1;
        return b;
    endfunction

    task automatic drain();
        int t;
        t = 0;
        ordy[0] = 1'b1;
        ordy[1] = 1'b1;
        while (busy() && t < 300) begin
            step();
            t++;
        end
        chk("drain_busy", 32'(busy()), 0);
    endtask

    initial begin
        logic [WIDTH-1:0] hold;
        n_rst = 1'b0;
        ordy[0] = 1'b1;
        ordy[1] = 1'b1;
        for (int u = 0; u < 2; u++)
            for (int i = 0; i < NUM; i++) begin
                len[u][i] = 1;
                seq[u][i] = 0;
            end
        apply();
        repeat (3) @(posedge clk);
        #1;
        n_rst = 1'b1;

        // fairness: every channel one beat, ch0 requests again after its first win
        step();
        len[0][0] = 1;
        len[1][0] = 1;
        apply();
        drain();

        // move the pointer to ch2, then a locked 3-beat packet on ch2
        len[0][1] = 1;
        apply();
        drain();
        len[0][0] = 2;
        len[0][1] = 2;
        len[0][2] = 3;
        apply();
        drain();

        // backpressure on a long ch1 packet
        len[0][1] = 6;
        apply();
        step();
        step();
        ordy[0] = 1'b0;
        step();
        hold = od[0];
        repeat (4) begin
            step();
            chk("stall_data", 32'(od[0]), 32'(hold));
        end
        ordy[0] = 1'b1;
        drain();

        // fixed priority: ch1 starves ch3 until it drops
        len[1][1] = 40;
        len[1][3] = 40;
        apply();
        repeat (8) step();
        len[1][1] = 0;
        apply();
        repeat (3) step();
        len[1][3] = 0;
        apply();
        drain();

        // reset while locked on ch3
        len[0][3] = 6;
        apply();
        repeat (3) step();
        n_rst = 1'b0;
        #1;
        chk("rst_async_valid", 32'(ov[0]), 0);
        for (int u = 0; u < 2; u++)
            for (int i = 0; i < NUM; i++) len[u][i] = 0;
        len[0][0] = 1;
        len[0][3] = 2;
        apply();
        repeat (2) @(posedge clk);
        #1;
        n_rst = 1'b1;
        drain();

        // random traffic with random backpressure
        for (int c = 0; c < 400; c++) begin
            step();
            for (int u = 0; u < 2; u++) begin
                ordy[u] = ($urandom % 4) != 0;
                for (int i = 0; i < NUM; i++)
                    if (len[u][i] == 0 && ($urandom % 4) == 0) len[u][i] = $urandom_range(1, 4);
            end
            apply();
        end
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
